// File: rtl/mxv_seq_nnbit_jkdim_relu.sv
// Sequential fully-connected layer core: o = act(W*X + b), one column per cycle,
// J parallel multiply-accumulate lanes, valid/ready on both sides.
module mxv_seq_nnbit_jkdim_relu #(
  parameter  int N = 8,
  parameter  int J = 3,
  parameter  int K = 3,
  localparam int A = 2*N + $clog2(K) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [J*K*N-1:0] g_input,
  input  logic [K*N-1:0]   e_input,
  input  logic [J*N-1:0]   b_input,
  input  logic             relu_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [J*A-1:0]   o
);

  localparam int KW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg;
  logic               in_ready_reg;
  logic               out_valid_reg;
  logic [J*A-1:0]     o_reg;
  logic [KW-1:0]      k_reg;
  logic [J*K*N-1:0]   w_reg;
  logic [K*N-1:0]     x_reg;
  logic               relu_reg;
  logic signed [A-1:0] acc_reg [J];

  logic signed [N-1:0] x_el;
  logic signed [A-1:0] sum [J];
  logic signed [A-1:0] res [J];

  assign x_el = x_reg[k_reg*N +: N];

  // One multiplier per row; the current column is selected by k_reg.
  for (genvar gi = 0; gi < J; gi++) begin : g_lane
    logic signed [N-1:0]   w_el;
    logic signed [2*N-1:0] prod;
    assign w_el    = w_reg[(gi*K + k_reg)*N +: N];
    assign prod    = w_el * x_el;
    assign sum[gi] = acc_reg[gi] + A'(prod);
    assign res[gi] = (relu_reg && sum[gi] < 0) ? '0 : sum[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      o_reg         <= '0;
      k_reg         <= '0;
      for (int j = 0; j < J; j++) acc_reg[j] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            w_reg    <= g_input;
            x_reg    <= e_input;
            relu_reg <= relu_en;
            for (int j = 0; j < J; j++)
              acc_reg[j] <= A'($signed(b_input[j*N +: N]));
            k_reg        <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= RUN;
          end else begin
            in_ready_reg <= 1'b1;
          end
        end
        RUN: begin
          for (int j = 0; j < J; j++) acc_reg[j] <= sum[j];
          k_reg <= k_reg + KW'(1);
          if (k_reg == KW'(K - 1)) begin
            for (int j = 0; j < J; j++) o_reg[j*A +: A] <= res[j];
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign o         = o_reg;

endmodule
